// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the three requesters and the register-file write port.
// The master side drives requests; the slave side (the arbiter) grants them and drives the write port.
interface regfile_wb_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 32
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_fmode;
    logic [5*NREQ-1:0]      req_reg;
    logic [DATA_W*NREQ-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   wenable;
    logic                   wfmode;
    logic [4:0]             wreg;
    logic [DATA_W-1:0]      wdata;

    modport master (
        output req_valid, req_fmode, req_reg, req_data,
        input  req_ready, wenable, wfmode, wreg, wdata
    );

    modport slave (
        input  req_valid, req_fmode, req_reg, req_data,
        output req_ready, wenable, wfmode, wreg, wdata
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's write port among load unit, FPU and ALU,
// plus a 64-entry pending-write scoreboard queried by the issue stage.
module regfile_wb_arbiter #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rstn,
    regfile_wb_arbiter_if.slave wb,
    input  logic                iss_valid,
    input  logic                iss_fmode,
    input  logic [4:0]          iss_reg,
    input  logic                q_fmode1,
    input  logic [4:0]          q_reg1,
    input  logic                q_fmode2,
    input  logic [4:0]          q_reg2,
    input  logic [4:0]          q_jr_reg,
    output logic                busy1,
    output logic                busy2,
    output logic                busy_jr
);
    localparam logic [1:0] LAST_IDX = 2'(NREQ - 1);

    logic [1:0]        last_grant_q, last_grant_d;
    logic [1:0]        grant_idx;
    logic              grant_vld;
    logic              wenable_q, wenable_d;
    logic              wfmode_q, wfmode_d;
    logic [4:0]        wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [63:0]       busy_q, busy_d;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == LAST_IDX) ? 2'd0 : idx + 2'd1;
    endfunction

    // Search starts just after the last granted requester; no grant while reset is held.
    always_comb begin
        logic [1:0] cand;
        grant_vld = 1'b0;
        grant_idx = last_grant_q;
        cand      = next_idx(last_grant_q);
        for (int k = 0; k < NREQ; k++) begin
            if (rstn && !grant_vld && wb.req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
            cand = next_idx(cand);
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign wb.req_ready[gi] = grant_vld && (grant_idx == 2'(gi));
        end
    endgenerate

    always_comb begin
        last_grant_d = last_grant_q;
        wenable_d    = grant_vld;
        wfmode_d     = wfmode_q;
        wreg_d       = wreg_q;
        wdata_d      = wdata_q;
        if (grant_vld) begin
            last_grant_d = grant_idx;
            wfmode_d     = wb.req_fmode[grant_idx];
            wreg_d       = wb.req_reg[5*grant_idx +: 5];
            wdata_d      = wb.req_data[DATA_W*grant_idx +: DATA_W];
        end
    end

    // Clear first, then set, so an issue to the entry being written leaves it busy.
    always_comb begin
        busy_d = busy_q;
        if (wenable_q) begin
            busy_d[{wfmode_q, wreg_q}] = 1'b0;
        end
        if (iss_valid) begin
            busy_d[{iss_fmode, iss_reg}] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_grant_q <= LAST_IDX;
            wenable_q    <= 1'b0;
            wfmode_q     <= 1'b0;
            wreg_q       <= 5'd0;
            wdata_q      <= '0;
            busy_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wenable_q    <= wenable_d;
            wfmode_q     <= wfmode_d;
            wreg_q       <= wreg_d;
            wdata_q      <= wdata_d;
            busy_q       <= busy_d;
        end
    end

    assign wb.wenable = wenable_q;
    assign wb.wfmode  = wfmode_q;
    assign wb.wreg    = wreg_q;
    assign wb.wdata   = wdata_q;

    assign busy1   = busy_q[{q_fmode1, q_reg1}];
    assign busy2   = busy_q[{q_fmode2, q_reg2}];
    assign busy_jr = busy_q[{1'b0, q_jr_reg}];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a randomized run
// compared against a behavioural model of grants, write port and scoreboard.
module tb_regfile_wb_arbiter;
    logic       clk = 1'b0;
    logic       rstn;
    logic       iss_valid, iss_fmode;
    logic [4:0] iss_reg;
    logic       q_fmode1, q_fmode2;
    logic [4:0] q_reg1, q_reg2, q_jr_reg;
    logic       busy1, busy2, busy_jr;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int          m_last;
    bit          m_busy [2][32];
    bit          m_we, m_fm;
    bit [4:0]    m_reg;
    bit [31:0]   m_data;

    regfile_wb_arbiter_if #(.NREQ(3), .DATA_W(32)) wb ();

    regfile_wb_arbiter #(.NREQ(3), .DATA_W(32)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .wb       (wb),
        .iss_valid(iss_valid),
        .iss_fmode(iss_fmode),
        .iss_reg  (iss_reg),
        .q_fmode1 (q_fmode1),
        .q_reg1   (q_reg1),
        .q_fmode2 (q_fmode2),
        .q_reg2   (q_reg2),
        .q_jr_reg (q_jr_reg),
        .busy1    (busy1),
        .busy2    (busy2),
        .busy_jr  (busy_jr)
    );

    always #5 clk = ~clk;

    // Requester that the rotating priority picks this cycle, or -1.
    function automatic int model_grant();
        if (!rstn) return -1;
        for (int k = 1; k <= 3; k++) begin
            if (wb.req_valid[(m_last + k) % 3]) return (m_last + k) % 3;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int g;
        g = model_grant();
        if (!rstn) begin
            m_we = 0; m_fm = 0; m_reg = 0; m_data = 0; m_last = 2;
            foreach (m_busy[a, b]) m_busy[a][b] = 0;
        end else begin
            if (m_we) m_busy[m_fm][m_reg] = 0;
            if (iss_valid) m_busy[iss_fmode][iss_reg] = 1;
            if (g >= 0) begin
                m_we   = 1;
                m_fm   = wb.req_fmode[g];
                m_reg  = wb.req_reg[g*5 +: 5];
                m_data = wb.req_data[g*32 +: 32];
                m_last = g;
                $display("xfer req%0d fmode=%0d reg=%0d data=%08h", g, m_fm, m_reg, m_data);
            end else begin
                m_we = 0;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        wb.req_valid = 3'b111;
        wb.req_fmode = 3'b010;
        wb.req_reg   = {5'd4, 5'd2, 5'd1};
        wb.req_data  = {32'h33333333, 32'h22222222, 32'h11111111};
        for (int c = 0; c < 2; c++) begin
            tick();
            total++; if (wb.wenable !== 1'b0) begin bad++; $display("FAIL reset_wenable: got %b want 0", wb.wenable); end
            total++; if (wb.req_ready !== 3'b000) begin bad++; $display("FAIL reset_ready: got %b want 000", wb.req_ready); end
            total++; if ({busy1, busy2, busy_jr} !== 3'b000) begin bad++; $display("FAIL reset_busy: got %b want 000", {busy1, busy2, busy_jr}); end
            total++; if ({wb.wfmode, wb.wreg, wb.wdata} !== 38'd0) begin bad++; $display("FAIL reset_wport: got %b/%0d/%h want 0", wb.wfmode, wb.wreg, wb.wdata); end
        end
        rstn = 1'b1;
        #1;
        total++; if (wb.req_ready !== 3'b001) begin bad++; $display("FAIL reset_first_grant: got %b want 001", wb.req_ready); end
        tick();
        wb.req_valid = 3'b000;
        total++; if (wb.wenable !== 1'b1 || wb.wreg !== 5'd1 || wb.wdata !== 32'h11111111) begin
            bad++; $display("FAIL reset_first_write: got we=%b reg=%0d data=%h want 1/1/11111111", wb.wenable, wb.wreg, wb.wdata); end
    endtask

    task automatic test_single_write();
        wb.req_valid[2]     = 1'b1;
        wb.req_fmode[2]     = 1'b0;
        wb.req_reg[14:10]   = 5'd5;
        wb.req_data[95:64]  = 32'hDEADBEEF;
        #1;
        total++; if (wb.req_ready !== 3'b100) begin bad++; $display("FAIL single_ready: got %b want 100", wb.req_ready); end
        tick();
        wb.req_valid = 3'b000;
        total++; if (wb.wenable !== 1'b1 || wb.wfmode !== 1'b0 || wb.wreg !== 5'd5 || wb.wdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL single_write: got we=%b f=%b reg=%0d data=%h want 1/0/5/deadbeef", wb.wenable, wb.wfmode, wb.wreg, wb.wdata); end
        tick();
        total++; if (wb.wenable !== 1'b0) begin bad++; $display("FAIL single_idle: got we=%b want 0", wb.wenable); end
        total++; if (wb.wdata !== 32'hDEADBEEF || wb.wreg !== 5'd5) begin
            bad++; $display("FAIL single_hold: got reg=%0d data=%h want 5/deadbeef", wb.wreg, wb.wdata); end
    endtask

    task automatic test_fairness();
        int exp_seq [10];
        int e;
        logic [31:0] exp_data;
        exp_seq = '{0, 1, 2, 0, 1, 2, 0, 2, 0, 2};
        wb.req_fmode = 3'b101;
        wb.req_reg   = {5'd12, 5'd11, 5'd10};
        wb.req_data  = {$urandom, $urandom, $urandom};
        wb.req_valid = 3'b111;
        for (int i = 0; i < 10; i++) begin
            if (i == 6) wb.req_valid[1] = 1'b0;
            e = exp_seq[i];
            #1;
            total++; if (wb.req_ready !== 3'(1 << e)) begin bad++; $display("FAIL fair_grant%0d: got %b want %b", i, wb.req_ready, 3'(1 << e)); end
            exp_data = wb.req_data[e*32 +: 32];
            tick();
            total++; if (wb.wenable !== 1'b1 || wb.wreg !== 5'(10 + e) || wb.wfmode !== (e != 1) || wb.wdata !== exp_data) begin
                bad++; $display("FAIL fair_write%0d: got we=%b f=%b reg=%0d data=%h want 1/%0d/%0d/%h", i, wb.wenable, wb.wfmode, wb.wreg, wb.wdata, (e != 1), 10 + e, exp_data); end
            wb.req_data[e*32 +: 32] = $urandom;
        end
        wb.req_valid = 3'b000;
    endtask

    task automatic test_scoreboard();
        iss_valid = 1'b1; iss_fmode = 1'b1; iss_reg = 5'd3;
        q_fmode1 = 1'b1; q_reg1 = 5'd3; q_fmode2 = 1'b0; q_reg2 = 5'd3;
        #1;
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL sb_no_bypass: got %b want 0", busy1); end
        tick();
        iss_valid = 1'b0;
        #1;
        total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL sb_float_busy: got %b want 1", busy1); end
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL sb_int_free: got %b want 0", busy2); end
        wb.req_valid[1] = 1'b1; wb.req_fmode[1] = 1'b1; wb.req_reg[9:5] = 5'd3; wb.req_data[63:32] = $urandom;
        #1;
        total++; if (wb.req_ready !== 3'b010) begin bad++; $display("FAIL sb_fpu_grant: got %b want 010", wb.req_ready); end
        tick();
        wb.req_valid = 3'b000;
        total++; if (wb.wenable !== 1'b1 || wb.wfmode !== 1'b1 || wb.wreg !== 5'd3) begin
            bad++; $display("FAIL sb_fpu_write: got we=%b f=%b reg=%0d want 1/1/3", wb.wenable, wb.wfmode, wb.wreg); end
        total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL sb_busy_n1: got %b want 1", busy1); end
        tick();
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL sb_busy_n2: got %b want 0", busy1); end
    endtask

    task automatic test_collision();
        iss_valid = 1'b1; iss_fmode = 1'b0; iss_reg = 5'd7;
        q_fmode2 = 1'b0; q_reg2 = 5'd7;
        tick();
        iss_valid = 1'b0;
        wb.req_valid[2] = 1'b1; wb.req_fmode[2] = 1'b0; wb.req_reg[14:10] = 5'd7; wb.req_data[95:64] = $urandom;
        tick();
        wb.req_valid = 3'b000;
        iss_valid = 1'b1; iss_fmode = 1'b0; iss_reg = 5'd7;
        total++; if (wb.wenable !== 1'b1 || wb.wreg !== 5'd7) begin bad++; $display("FAIL coll_write: got we=%b reg=%0d want 1/7", wb.wenable, wb.wreg); end
        tick();
        iss_valid = 1'b0;
        total++; if (busy2 !== 1'b1) begin bad++; $display("FAIL coll_set_wins: got %b want 1", busy2); end
        tick();
        total++; if (busy2 !== 1'b1) begin bad++; $display("FAIL coll_stays: got %b want 1", busy2); end
    endtask

    task automatic test_jr();
        iss_valid = 1'b1; iss_fmode = 1'b1; iss_reg = 5'd29;
        tick();
        q_jr_reg = 5'd29; q_fmode1 = 1'b1; q_reg1 = 5'd29;
        iss_valid = 1'b1; iss_fmode = 1'b0; iss_reg = 5'd31;
        #1;
        total++; if (busy_jr !== 1'b0 || busy1 !== 1'b1) begin bad++; $display("FAIL jr_int_only: got jr=%b b1=%b want 0/1", busy_jr, busy1); end
        tick();
        iss_valid = 1'b0;
        q_jr_reg = 5'd31;
        #1;
        total++; if (busy_jr !== 1'b1) begin bad++; $display("FAIL jr_busy: got %b want 1", busy_jr); end
        wb.req_valid[0] = 1'b1; wb.req_fmode[0] = 1'b0; wb.req_reg[4:0] = 5'd31; wb.req_data[31:0] = $urandom;
        tick();
        wb.req_valid = 3'b000;
        total++; if (busy_jr !== 1'b1) begin bad++; $display("FAIL jr_busy_n1: got %b want 1", busy_jr); end
        tick();
        total++; if (busy_jr !== 1'b0) begin bad++; $display("FAIL jr_cleared: got %b want 0", busy_jr); end
    endtask

    task automatic test_reset_mid();
        iss_valid = 1'b1; iss_fmode = 1'b0; iss_reg = 5'd12;
        tick();
        iss_fmode = 1'b1; iss_reg = 5'd10;
        tick();
        iss_valid = 1'b0;
        q_fmode1 = 1'b1; q_reg1 = 5'd10; q_fmode2 = 1'b0; q_reg2 = 5'd12; q_jr_reg = 5'd12;
        wb.req_valid = 3'b011;
        wb.req_fmode[1:0] = 2'b10;
        wb.req_reg[9:0] = {5'd20, 5'd21};
        wb.req_data[63:0] = {32'hCAFEF00D, 32'h0BADC0DE};
        #1;
        total++; if ({busy1, busy2, busy_jr} !== 3'b111) begin bad++; $display("FAIL mid_busy_pre: got %b want 111", {busy1, busy2, busy_jr}); end
        total++; if (wb.req_ready !== 3'b010) begin bad++; $display("FAIL mid_grant_pre: got %b want 010", wb.req_ready); end
        tick();
        wb.req_valid[1] = 1'b0;
        rstn = 1'b0;
        #1;
        total++; if (wb.req_ready !== 3'b000) begin bad++; $display("FAIL mid_ready_rst: got %b want 000", wb.req_ready); end
        tick();
        total++; if (wb.wenable !== 1'b0 || wb.wreg !== 5'd0 || wb.wdata !== 32'd0) begin
            bad++; $display("FAIL mid_wport_rst: got we=%b reg=%0d data=%h want 0/0/0", wb.wenable, wb.wreg, wb.wdata); end
        total++; if ({busy1, busy2, busy_jr} !== 3'b000) begin bad++; $display("FAIL mid_busy_rst: got %b want 000", {busy1, busy2, busy_jr}); end
        rstn = 1'b1;
        #1;
        total++; if (wb.req_ready !== 3'b001) begin bad++; $display("FAIL mid_regrant: got %b want 001", wb.req_ready); end
        tick();
        wb.req_valid = 3'b000;
        total++; if (wb.wenable !== 1'b1 || wb.wreg !== 5'd21 || wb.wdata !== 32'h0BADC0DE) begin
            bad++; $display("FAIL mid_rewrite: got we=%b reg=%0d data=%h want 1/21/0badc0de", wb.wenable, wb.wreg, wb.wdata); end
    endtask

    task automatic test_random();
        int g;
        logic [2:0] exp_ready;
        wb.req_valid = 3'b000;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (!wb.req_valid[i] && $urandom_range(0, 2) == 0) begin
                    wb.req_valid[i]       = 1'b1;
                    wb.req_fmode[i]       = 1'($urandom_range(0, 1));
                    wb.req_reg[i*5 +: 5]  = 5'($urandom_range(0, 7));
                    wb.req_data[i*32 +: 32] = $urandom;
                end
            end
            iss_valid = 1'($urandom_range(0, 1));
            iss_fmode = 1'($urandom_range(0, 1));
            iss_reg   = 5'($urandom_range(0, 7));
            q_fmode1  = 1'($urandom_range(0, 1));
            q_reg1    = 5'($urandom_range(0, 7));
            q_fmode2  = 1'($urandom_range(0, 1));
            q_reg2    = 5'($urandom_range(0, 7));
            q_jr_reg  = 5'($urandom_range(0, 7));
            #1;
            g = model_grant();
            exp_ready = (g < 0) ? 3'b000 : 3'(1 << g);
            total++; if (wb.req_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready@%0d: got %b want %b", n, wb.req_ready, exp_ready); end
            total++; if ({busy1, busy2, busy_jr} !== {m_busy[q_fmode1][q_reg1], m_busy[q_fmode2][q_reg2], m_busy[0][q_jr_reg]}) begin
                bad++; $display("FAIL rnd_busy@%0d: got %b want %b", n, {busy1, busy2, busy_jr},
                                {m_busy[q_fmode1][q_reg1], m_busy[q_fmode2][q_reg2], m_busy[0][q_jr_reg]}); end
            tick();
            total++; if (wb.wenable !== m_we || wb.wfmode !== m_fm || wb.wreg !== m_reg || wb.wdata !== m_data) begin
                bad++; $display("FAIL rnd_wport@%0d: got %b/%b/%0d/%h want %b/%b/%0d/%h", n, wb.wenable, wb.wfmode, wb.wreg, wb.wdata, m_we, m_fm, m_reg, m_data); end
            if (g >= 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    wb.req_valid[g] = 1'b0;
                end else begin
                    wb.req_fmode[g]         = 1'($urandom_range(0, 1));
                    wb.req_reg[g*5 +: 5]    = 5'($urandom_range(0, 7));
                    wb.req_data[g*32 +: 32] = $urandom;
                end
            end
        end
        wb.req_valid = 3'b000;
        iss_valid = 1'b0;
    endtask

    initial begin
        m_last = 2; m_we = 0; m_fm = 0; m_reg = 0; m_data = 0;
        foreach (m_busy[a, b]) m_busy[a][b] = 0;
        rstn = 1'b0;
        iss_valid = 1'b0; iss_fmode = 1'b0; iss_reg = 5'd0;
        q_fmode1 = 1'b0; q_reg1 = 5'd0; q_fmode2 = 1'b0; q_reg2 = 5'd0; q_jr_reg = 5'd0;
        wb.req_valid = 3'b000; wb.req_fmode = 3'b000; wb.req_reg = '0; wb.req_data = '0;
        #1;
        test_reset();
        test_single_write();
        test_fairness();
        test_scoreboard();
        test_collision();
        test_jr();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
